// File: rtl/zrb_spi_slave_pkg.sv
// Shared definitions for the zrb SPI responder: FSM states, SPI mode, dummy fill byte.
package zrb_spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    // Mode 0: CPOL=0, CPHA=0 -- SCK idles low, data sampled on the rising edge.
    localparam int unsigned SPI_MODE           = 0;
    localparam logic        SCK_IDLE_LEVEL     = (SPI_MODE >= 2);
    localparam logic [7:0]  DUMMY_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/zrb_sync_edge.sv
// Two-flop synchroniser plus a third flop for edge detection of an asynchronous pin.
module zrb_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic edge_o
);

    logic [2:0] sync_q;

    // Shift the pin through the synchroniser chain; reset to the pin's idle level.
    always_ff @(posedge clk_i) begin
        if (reset_i) sync_q <= {3{RESET_VAL}};
        else         sync_q <= {sync_q[1:0], d_i};
    end

    assign level_o = sync_q[1];
    assign edge_o  = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/zrb_sync_fifo.sv
// Small synchronous FIFO, first-word fall-through; writes when full and reads when empty are ignored.
module zrb_sync_fifo #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  wr_en, rd_en;

    assign full_o  = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_en   = we_i & ~full_o;
    assign rd_en   = re_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/zrb_spi_slave.sv
// SPI mode-0 responder: oversampled pins, TX/RX byte FIFOs toward the local host.
module zrb_spi_slave
    import zrb_spi_slave_pkg::*;
#(
    parameter int unsigned          NUM_BITS        = 8,
    parameter int unsigned          FIFO_ADDR_WIDTH = 2,
    parameter logic [NUM_BITS-1:0]  DUMMY_BYTE      = NUM_BITS'(DUMMY_BYTE_DEFAULT)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                sck_i,
    input  logic                ss_i,
    input  logic                mosi_i,
    output logic                miso_o,
    output logic                miso_oe_o,
    input  logic                tx_we_i,
    input  logic [NUM_BITS-1:0] tx_data_i,
    output logic                tx_full_o,
    input  logic                rx_re_i,
    output logic [NUM_BITS-1:0] rx_data_o,
    output logic                rx_empty_o,
    output logic                rx_byte_done_o,
    output logic                overrun_o,
    output logic                underrun_o,
    input  logic                clr_flags_i,
    output logic                busy_o
);

    localparam int unsigned CNT_W = $clog2(NUM_BITS);

    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                byte_seen_q, byte_seen_d;
    logic [NUM_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [NUM_BITS-2:0] rx_shift_q, rx_shift_d;
    logic [NUM_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                rx_push_q, rx_push_d;
    logic                overrun_q, overrun_d;
    logic                underrun_q, underrun_d;
    logic                mosi_meta_q, mosi_sync_q;

    logic                sck_level, sck_edge, ss_level, ss_edge;
    logic                sck_rise, sck_fall, ss_rise, ss_fall;
    logic                tx_pop, tx_empty, rx_full;
    logic [NUM_BITS-1:0] tx_head;

    zrb_sync_edge #(.RESET_VAL(SCK_IDLE_LEVEL)) u_sck_sync (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(sck_i), .level_o(sck_level), .edge_o(sck_edge)
    );

    zrb_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(ss_i), .level_o(ss_level), .edge_o(ss_edge)
    );

    zrb_sync_fifo #(.ADDR_WIDTH(FIFO_ADDR_WIDTH), .DATA_WIDTH(NUM_BITS)) u_tx_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .we_i(tx_we_i), .wdata_i(tx_data_i),
        .re_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full_o), .empty_o(tx_empty)
    );

    zrb_sync_fifo #(.ADDR_WIDTH(FIFO_ADDR_WIDTH), .DATA_WIDTH(NUM_BITS)) u_rx_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .we_i(rx_push_q), .wdata_i(rx_byte_q),
        .re_i(rx_re_i), .rdata_o(rx_data_o), .full_o(rx_full), .empty_o(rx_empty_o)
    );

    assign sck_rise = sck_edge &  sck_level;
    assign sck_fall = sck_edge & ~sck_level;
    assign ss_rise  = ss_edge  &  ss_level;
    assign ss_fall  = ss_edge  & ~ss_level;

    assign busy_o         = ~ss_level;
    assign miso_oe_o      = busy_o;
    assign miso_o         = miso_oe_o & tx_shift_q[NUM_BITS-1];
    assign rx_byte_done_o = rx_push_q;
    assign overrun_o      = overrun_q;
    assign underrun_o     = underrun_q;

    // MOSI only needs the plain two-flop synchroniser; it is sampled on synced SCK rises.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= mosi_i;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Frame state, shift registers and sticky flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_seen_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_push_q   <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_seen_q <= byte_seen_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_push_q   <= rx_push_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    // Next-state logic: ss rise has priority over any SCK edge; flag sets beat clr_flags.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_seen_d = byte_seen_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_push_d   = 1'b0;
        tx_pop      = 1'b0;
        overrun_d   = clr_flags_i ? 1'b0 : overrun_q;
        underrun_d  = clr_flags_i ? 1'b0 : underrun_q;

        if (rx_push_q && rx_full) overrun_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (tx_empty) begin
                    tx_shift_d = DUMMY_BYTE;
                    underrun_d = 1'b1;
                end else begin
                    tx_shift_d = tx_head;
                    tx_pop     = 1'b1;
                end
                bit_cnt_d   = '0;
                byte_seen_d = 1'b0;
                state_d     = ss_rise ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[NUM_BITS-3:0], mosi_sync_q};
                    if (bit_cnt_q == CNT_W'(NUM_BITS-1)) begin
                        bit_cnt_d   = '0;
                        byte_seen_d = 1'b1;
                        rx_push_d   = 1'b1;
                        rx_byte_d   = {rx_shift_q, mosi_sync_q};
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    // bit_cnt==0 on a fall means either "before first bit" (hold MSB) or a byte boundary (reload).
                    if (bit_cnt_q == '0) begin
                        if (byte_seen_q) begin
                            if (tx_empty) begin
                                tx_shift_d = DUMMY_BYTE;
                                underrun_d = 1'b1;
                            end else begin
                                tx_shift_d = tx_head;
                                tx_pop     = 1'b1;
                            end
                        end
                    end else begin
                        tx_shift_d = {tx_shift_q[NUM_BITS-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_zrb_spi_slave.sv
// Scoreboard bench for zrb_spi_slave: directed SPI bursts, queued expectations, decoupled monitors.
module tb_zrb_spi_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic       tx_we = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_full;
    logic       rx_re = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty, rx_byte_done, overrun, underrun, busy;
    logic       clr_flags = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] mbuf[8];

    always #5 clk = ~clk;

    zrb_spi_slave #(.NUM_BITS(8), .FIFO_ADDR_WIDTH(2), .DUMMY_BYTE(8'hFF)) dut (
        .clk_i(clk), .reset_i(reset), .sck_i(sck), .ss_i(ss), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .tx_we_i(tx_we), .tx_data_i(tx_data),
        .tx_full_o(tx_full), .rx_re_i(rx_re), .rx_data_o(rx_data), .rx_empty_o(rx_empty),
        .rx_byte_done_o(rx_byte_done), .overrun_o(overrun), .underrun_o(underrun),
        .clr_flags_i(clr_flags), .busy_o(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk);
        tx_we   = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_we   = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    // Mode-0 master at clk/10; last SCK fall coincides with SS rise.
    task automatic spi_burst(input int nbits);
        ss = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = mbuf[i/8][7-(i%8)];
            repeat (5) @(negedge clk);
            sck = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
            if (i == nbits - 1) ss = 1'b1;
        end
        mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Host-side monitor: counts byte-done pulses and checks every popped RX byte.
    logic [7:0] e_rx;
    always begin
        @(negedge clk);
        #1;
        if (rx_byte_done === 1'b1) done_cnt++;
        if (rx_re === 1'b1 && rx_empty === 1'b0) begin
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data);
            end else begin
                e_rx = exp_rx.pop_front();
                check("rx_data", 32'(rx_data), 32'(e_rx));
            end
        end
    end

    // Master-side monitor: assembles MISO bits on SCK rises, discards partial bytes at SS rise.
    logic [7:0] mshift = 8'h00;
    int         mbits = 0;
    logic [7:0] e_miso;
    always begin
        @(posedge sck or posedge ss);
        if (ss === 1'b1) begin
            mbits = 0;
        end else begin
            mshift = {mshift[6:0], miso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_miso.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL miso_unexpected: got %0h expected none", mshift);
                end else begin
                    e_miso = exp_miso.pop_front();
                    check("miso_byte", 32'(mshift), 32'(e_miso));
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        #1;
        check("rst_miso", 32'(miso), 0);
        check("rst_miso_oe", 32'(miso_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(rx_byte_done), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_rx_empty", 32'(rx_empty), 1);
        check("rst_tx_full", 32'(tx_full), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single byte both ways
        push_tx(8'hA5);
        exp_miso.push_back(8'hA5);
        mbuf[0] = 8'h3C;
        exp_rx.push_back(8'h3C);
        spi_burst(8);
        check("t1_done", 32'(done_cnt), 1);
        check("t1_underrun", 32'(underrun), 0);
        check("t1_overrun", 32'(overrun), 0);
        check("t1_rx_empty", 32'(rx_empty), 0);
        pop_rx();

        // 2: TX underrun sends dummy, clear flag
        mbuf[0] = 8'hC3;
        exp_miso.push_back(8'hFF);
        exp_rx.push_back(8'hC3);
        spi_burst(8);
        check("t2_underrun_set", 32'(underrun), 1);
        pulse_clr();
        #1;
        check("t2_underrun_clr", 32'(underrun), 0);
        check("t2_done", 32'(done_cnt), 2);
        pop_rx();

        // 3: 5-byte burst into a 4-deep RX FIFO
        for (int i = 0; i < 5; i++) begin
            mbuf[i] = 8'(i + 1);
            exp_miso.push_back(8'hFF);
        end
        for (int i = 0; i < 4; i++) exp_rx.push_back(8'(i + 1));
        spi_burst(40);
        check("t3_done", 32'(done_cnt), 7);
        check("t3_overrun", 32'(overrun), 1);
        for (int i = 0; i < 4; i++) pop_rx();
        #1;
        check("t3_rx_drained", 32'(rx_empty), 1);
        pulse_clr();
        #1;
        check("t3_overrun_clr", 32'(overrun), 0);

        // 4: three queued TX bytes across a burst
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        #1;
        check("t4_tx_full", 32'(tx_full), 0);
        mbuf[0] = 8'hAA; mbuf[1] = 8'hBB; mbuf[2] = 8'hCC;
        exp_miso.push_back(8'h11); exp_miso.push_back(8'h22); exp_miso.push_back(8'h33);
        exp_rx.push_back(8'hAA); exp_rx.push_back(8'hBB); exp_rx.push_back(8'hCC);
        spi_burst(24);
        check("t4_done", 32'(done_cnt), 10);
        check("t4_underrun", 32'(underrun), 0);
        for (int i = 0; i < 3; i++) pop_rx();

        // 5: aborted byte then a clean one
        mbuf[0] = 8'hFF;
        spi_burst(5);
        check("t5_rx_empty", 32'(rx_empty), 1);
        check("t5_no_done", 32'(done_cnt), 10);
        mbuf[0] = 8'h81;
        exp_miso.push_back(8'hFF);
        exp_rx.push_back(8'h81);
        spi_burst(8);
        check("t5_done", 32'(done_cnt), 11);
        check("t5_underrun", 32'(underrun), 1);
        pop_rx();

        // 6: reset mid-byte with both FIFOs holding data and a flag set
        push_tx(8'h44);
        push_tx(8'h55);
        push_tx(8'h66);
        mbuf[0] = 8'h5A;
        exp_miso.push_back(8'h44);
        spi_burst(8);
        check("t6_rx_loaded", 32'(rx_empty), 0);
        ss = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("t6_rx_empty", 32'(rx_empty), 1);
        check("t6_miso_oe", 32'(miso_oe), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_underrun", 32'(underrun), 0);
        check("t6_overrun", 32'(overrun), 0);
        ss = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        // TX must have been emptied by reset, so the next byte is the dummy
        mbuf[0] = 8'h77;
        exp_miso.push_back(8'hFF);
        exp_rx.push_back(8'h77);
        spi_burst(8);
        check("t6_done", 32'(done_cnt), 13);
        pop_rx();
        #1;
        check("t6_rx_final_empty", 32'(rx_empty), 1);

        repeat (5) @(negedge clk);
        check("sb_rx_leftover", 32'(exp_rx.size()), 0);
        check("sb_miso_leftover", 32'(exp_miso.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
